// File: rtl/div_unit_if.sv
// ----------------------------------------------------------------------------
// div_unit_if -- EX-stage <-> divide unit signal bundle.
//
// Signal names keep the divider's point of view: *_i are driven by the
// pipeline (EX / ctrl) into the divider, *_o are driven by the divider.
//   start_i     : EX requests a divide this cycle
//   op_i        : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i  : rs1 value
//   divisor_i   : rs2 value
//   rd_addr_i   : destination register
//   jump_en_i   : pipeline flush from ctrl, cancels an in-flight divide
//   hold_req_o  : stall request towards ctrl
//   busy_o      : divider is in CALC or END
//   ready_o     : one-cycle result-valid strobe
//   we_o        : register-file write enable (same as ready_o)
//   result_o    : quotient or remainder, zero when ready_o is low
//   rd_addr_o   : captured destination register, zero when ready_o is low
//
// Modports: master = pipeline side, slave = divide unit.
// ----------------------------------------------------------------------------
interface div_unit_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        jump_en_i;
  logic        hold_req_o;
  logic        busy_o;
  logic        ready_o;
  logic        we_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_addr_i, jump_en_i,
    input  hold_req_o, busy_o, ready_o, we_o, result_o, rd_addr_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, jump_en_i,
    output hold_req_o, busy_o, ready_o, we_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit -- multi-cycle 32-bit restoring divider for DIV/DIVU/REM/REMU.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : div_unit_if.slave (request, flush, stall and writeback signals)
//
// A divide accepted in IDLE runs 32 restoring steps in CALC (one bit per
// cycle) on operand magnitudes, then presents the sign-corrected result for
// one cycle in END. Divide-by-zero and signed overflow skip CALC and go
// straight to END with their architected results. A flush during CALC
// cancels the operation; once in END the instruction is committed and the
// writeback strobe is always produced.
// ----------------------------------------------------------------------------
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_END  = 2'b10;

  localparam logic [4:0]  LAST_STEP = 5'd31;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

  logic [1:0]  state_q,     state_d;
  logic [4:0]  step_q,      step_d;
  logic [1:0]  op_q,        op_d;
  logic [4:0]  rd_q,        rd_d;
  logic [31:0] dvd_q,       dvd_d;       // dividend magnitude, shifted out MSB first
  logic [31:0] dvs_q,       dvs_d;       // divisor magnitude
  logic [31:0] quot_q,      quot_d;
  logic [32:0] rem_q,       rem_d;       // partial remainder, bit 32 is the borrow
  logic        neg_quot_q,  neg_quot_d;
  logic        neg_rem_q,   neg_rem_d;
  logic [31:0] result_q,    result_d;

  // One restoring step, evaluated every cycle and only committed in CALC.
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        quot_bit;
  logic [32:0] rem_step;
  logic [31:0] quot_step;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign rem_shift = {rem_q[31:0], dvd_q[31]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};
  assign quot_bit  = ~rem_diff[32];
  assign rem_step  = quot_bit ? rem_diff : rem_shift;
  assign quot_step = {quot_q[30:0], quot_bit};
  // Quotient sign follows the XOR of operand signs, remainder follows the dividend.
  assign quot_fix  = neg_quot_q ? -quot_step : quot_step;
  assign rem_fix   = neg_rem_q ? -rem_step[31:0] : rem_step[31:0];

  logic        is_signed;
  logic        accept;

  assign is_signed = ~bus.op_i[0];
  assign accept    = (state_q == ST_IDLE) && bus.start_i && !bus.jump_en_i;

  always_comb begin
    // NOTE: every next-state signal starts from its current value so that no
    // branch below can leave one unassigned and infer a latch.
    state_d    = state_q;
    step_d     = step_q;
    op_d       = op_q;
    rd_d       = rd_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d       = bus.op_i;
          rd_d       = bus.rd_addr_i;
          dvd_d      = is_signed ? abs32(bus.dividend_i) : bus.dividend_i;
          dvs_d      = is_signed ? abs32(bus.divisor_i)  : bus.divisor_i;
          quot_d     = '0;
          rem_d      = '0;
          step_d     = '0;
          neg_quot_d = is_signed & (bus.dividend_i[31] ^ bus.divisor_i[31]);
          neg_rem_d  = is_signed & bus.dividend_i[31];
          if (bus.divisor_i == '0) begin
            // Divide by zero: quotient all ones, remainder is the raw dividend.
            state_d  = ST_END;
            result_d = bus.op_i[1] ? bus.dividend_i : '1;
          end else if (is_signed && bus.dividend_i == INT_MIN && bus.divisor_i == '1) begin
            // Signed overflow: quotient wraps to INT_MIN, remainder zero.
            state_d  = ST_END;
            result_d = bus.op_i[1] ? '0 : INT_MIN;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (bus.jump_en_i) begin
          state_d = ST_IDLE;
        end else begin
          dvd_d  = {dvd_q[30:0], 1'b0};
          rem_d  = rem_step;
          quot_d = quot_step;
          step_d = step_q + 5'd1;
          if (step_q == LAST_STEP) begin
            state_d  = ST_END;
            result_d = op_q[1] ? rem_fix : quot_fix;
          end
        end
      end

      // A flush arriving here is ignored: the instruction has committed.
      ST_END:  state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

  // Outputs are forced low while reset is held so the pipeline never sees a
  // stall or writeback from a unit that is being reset.
  logic ready;

  assign ready          = rst && (state_q == ST_END);
  assign bus.hold_req_o = rst && (accept || (state_q == ST_CALC));
  assign bus.busy_o     = rst && ((state_q == ST_CALC) || (state_q == ST_END));
  assign bus.ready_o    = ready;
  assign bus.we_o       = ready;
  assign bus.result_o   = ready ? result_q : '0;
  assign bus.rd_addr_o  = ready ? rd_q : '0;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL: start_i  input  1  EX requests a divide this cycle.
REQ-004 SHALL: op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-005 SHALL: dividend_i  input  32  rs1 value.
REQ-006 SHALL: divisor_i  input  32  rs2 value.
REQ-007 SHALL: rd_addr_i  input  5  destination register.
REQ-008 SHALL: jump_en_i  input  1  pipeline flush from ctrl; cancels the operation.
REQ-009 SHALL: hold_req_o  output  1  stall request, drives the ctrl hold_flag input.
REQ-010 SHALL: busy_o  output  1  high while in CALC or END.
REQ-011 SHALL: ready_o  output  1  one-cycle result-valid strobe.
REQ-012 SHALL: we_o  output  1  register-file write enable, equal to ready_o.
REQ-013 SHALL: result_o  output  32  quotient or remainder per captured op.
REQ-014 SHALL: rd_addr_o  output  5  captured rd_addr_i.

Function
REQ-015 SHALL: FSM states IDLE, CALC, END.
REQ-016 SHALL: In IDLE with start_i=1 and jump_en_i=0, capture op_i, rd_addr_i and operand magnitudes at the edge.
REQ-017 SHALL: Signed ops use absolute values; unsigned ops use raw operands.
REQ-018 SHALL: After capture, enter CALC with iteration counter cleared.
REQ-019 SHALL: Divisor zero or signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM) go IDLE->END directly.
REQ-020 SHALL: In CALC, one restoring-division step per cycle: shift the 33-bit partial remainder left with the next dividend bit, subtract the divisor if non-negative, shift the quotient bit in.
REQ-021 SHALL: After exactly 32 CALC cycles, go to END.
REQ-022 SHALL: Normal latency is 33 cycles: start accepted at edge N, ready_o high in the cycle following edge N+32.
REQ-023 SHALL: Special-case latency is 1 cycle: ready_o high in the cycle following edge N.
REQ-024 SHALL: In END, assert ready_o=we_o=1 for exactly one cycle, hold result_o and rd_addr_o valid, then go to IDLE.
REQ-025 SHALL: Signed quotient is negated when operand signs differ.
REQ-026 SHALL: Signed remainder takes the sign of the dividend.
REQ-027 SHALL: Divide by zero yields quotient 0xFFFFFFFF and remainder = dividend_i, for both signed and unsigned ops.
REQ-028 SHALL: Signed overflow yields quotient 0x80000000 and remainder 0.
REQ-029 SHALL: hold_req_o = (IDLE & start_i & !jump_en_i) | CALC, combinational, so the start cycle stalls IF/ID/EX.
REQ-030 SHALL: hold_req_o is 0 in END, releasing the pipeline as the result writes back.
REQ-031 SHALL: jump_en_i=1 in CALC aborts to IDLE at the next edge, with no ready_o/we_o pulse.
REQ-032 SHALL: jump_en_i=1 in END does not suppress ready_o/we_o, because the instruction is already committed.
REQ-033 SHALL: start_i is ignored outside IDLE.
REQ-034 SHALL: Back-to-back start_i in the IDLE cycle following END is accepted normally.
REQ-035 SHALL: result_o and rd_addr_o are 0 whenever ready_o=0.

Reset
REQ-036 SHALL: rst=0 at a clock edge forces IDLE and clears the counter, operand/quotient/remainder registers and captured fields.
REQ-037 SHALL: Outputs during and after reset: hold_req_o=0, busy_o=0, ready_o=0, we_o=0, result_o=0, rd_addr_o=0.
REQ-038 SHALL: Reset asserted mid-CALC abandons the operation with no ready_o pulse.

Verification
REQ-039 SHALL: DIVU 100/7, rd=5 -> hold_req_o high for 33 cycles starting at the start cycle; ready_o single pulse 33 cycles after accept; result_o=14, rd_addr_o=5.
REQ-040 SHALL: DIV -7/2, then REM -7/2 -> result_o=0xFFFFFFFD (-3), then 0xFFFFFFFF (-1).
REQ-041 SHALL: DIV 0x80000000/0xFFFFFFFF -> result_o=0x80000000 one cycle after accept; REM of the same operands -> 0.
REQ-042 SHALL: REMU 12345/0 -> result_o=12345; DIVU 12345/0 -> 0xFFFFFFFF; both with 1-cycle latency.
REQ-043 SHALL: Start DIVU, pulse jump_en_i at CALC cycle 10 -> IDLE next cycle, hold_req_o=0, no ready_o/we_o pulse; next start produces a correct result.
REQ-044 SHALL: rst=0 at CALC cycle 20 -> all outputs 0 at the next edge; start_i asserted while busy is ignored, and the in-flight result is unchanged.
